// File: rtl/codiq_seq_pkg.sv
// Shared state type and defaults for the IQ coder TX sequencer.
// 50 MHz clock / 25 clocks per chip = 2 Mchip/s.
package codiq_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        GAP
    } seq_state_t;

    localparam int DEF_CLK_PER_CHIP = 25;
    localparam int DEF_GAP_CYCLES   = 43;
    localparam int DEF_FLUSH_CHIPS  = 2;
    localparam int DEF_LEN_W        = 12;

    function automatic int cnt_width(input int maxval);
        if (maxval < 1) return 1;
        return $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/codiq_chip_timer.sv
// Loadable down-counter with freeze and zero flag.
// Stops at zero; load has priority over counting.
module codiq_chip_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/codiq_tx_sequencer.sv
// TX sequencer: paces FIFO chips into the IQ coder at one chip per
// CLK_PER_CHIP clocks, then flushes and holds an inter-frame gap.
module codiq_tx_sequencer
    import codiq_seq_pkg::*;
#(
    parameter int CLK_PER_CHIP = DEF_CLK_PER_CHIP,
    parameter int LEN_W        = DEF_LEN_W,
    parameter int FLUSH_CHIPS  = DEF_FLUSH_CHIPS,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             chip_valid,
    input  logic             chip_data,
    output logic             chip_rd,
    input  logic             dac_ready,
    input  logic             cod_ready,
    output logic             b_in,
    output logic             en_2MHz,
    output logic             mem_state,
    output logic             busy,
    output logic             done,
    output logic             underrun,
    output logic [LEN_W-1:0] chip_cnt
);

    localparam int FL_LEN = FLUSH_CHIPS * CLK_PER_CHIP;
    localparam int FT_MAX = (FL_LEN > GAP_CYCLES) ? FL_LEN - 1
                                                  : GAP_CYCLES - 1;
    localparam int CT_W   = cnt_width(CLK_PER_CHIP - 1);
    localparam int FT_W   = cnt_width(FT_MAX);

    localparam logic [CT_W-1:0] CT_RELOAD = CT_W'(CLK_PER_CHIP - 1);
    localparam logic [FT_W-1:0] FT_FLUSH  = FT_W'(FL_LEN - 1);
    localparam logic [FT_W-1:0] FT_GAP    = FT_W'(GAP_CYCLES - 1);

    seq_state_t       state;
    seq_state_t       state_nx;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_nx;
    logic [LEN_W-1:0] cnt_nx;
    logic             strobe;
    logic             done_nx;
    logic             ct_load;
    logic             ct_zero;
    logic [CT_W-1:0]  ct_val;
    logic             ft_load;
    logic             ft_en;
    logic             ft_zero;
    logic [FT_W-1:0]  ft_val;

    codiq_chip_timer #(.W(CT_W)) u_chip_tmr (
        .clk      (clk),
        .resetn   (resetn),
        .load     (ct_load),
        .load_val (ct_val),
        .en       (dac_ready),
        .zero     (ct_zero)
    );

    // FLUSH counts only while the DAC accepts; GAP always runs.
    assign ft_en = dac_ready || (state == GAP);

    codiq_chip_timer #(.W(FT_W)) u_frame_tmr (
        .clk      (clk),
        .resetn   (resetn),
        .load     (ft_load),
        .load_val (ft_val),
        .en       (ft_en),
        .zero     (ft_zero)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        len_nx   = len_q;
        cnt_nx   = chip_cnt;
        strobe   = 1'b0;
        done_nx  = 1'b0;
        ct_load  = 1'b0;
        ct_val   = '0;
        ft_load  = 1'b0;
        ft_val   = FT_GAP;
        unique case (state)
            IDLE: begin
                if (start && (frame_len != '0)) begin
                    state_nx = RUN;
                    len_nx   = frame_len;
                    cnt_nx   = '0;
                    ct_load  = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = GAP;
                    ft_load  = 1'b1;
                end else if (ct_zero && cod_ready && dac_ready) begin
                    strobe  = 1'b1;
                    cnt_nx  = chip_cnt + LEN_W'(1);
                    ct_load = 1'b1;
                    ct_val  = CT_RELOAD;
                    if (cnt_nx == len_q) begin
                        state_nx = FLUSH;
                        ft_load  = 1'b1;
                        ft_val   = FT_FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (abort || (ft_zero && dac_ready)) begin
                    state_nx = GAP;
                    ft_load  = 1'b1;
                end
            end
            GAP: begin
                if (ft_zero) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            len_q     <= '0;
            chip_cnt  <= '0;
            b_in      <= 1'b0;
            en_2MHz   <= 1'b0;
            chip_rd   <= 1'b0;
            underrun  <= 1'b0;
            mem_state <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            len_q     <= len_nx;
            chip_cnt  <= cnt_nx;
            en_2MHz   <= strobe;
            chip_rd   <= strobe && chip_valid;
            underrun  <= strobe && !chip_valid;
            mem_state <= (state_nx == RUN) || (state_nx == FLUSH);
            busy      <= (state_nx != IDLE);
            done      <= done_nx;
            if (strobe) begin
                b_in <= chip_valid && chip_data;
            end
        end
    end

endmodule
